// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I front end
package riscv_pkg;
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_source_t;
  typedef enum logic [1:0] {
    REQ   = 2'b00,
    WAIT  = 2'b01,
    VALID = 2'b10,
    HALT  = 2'b11
  } fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/next_pc_unit.sv
// next_pc_unit: next-PC select with word-alignment check
module next_pc_unit import riscv_pkg::*; (
  input  logic [31:0] pc,
  input  logic [1:0]  pc_source,
  input  logic [31:0] immediate,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  assign next_pc = pc_source == PC_BRANCH ? pc + immediate
                 : pc_source == PC_JALR   ? alu_result & ~32'h1
                 : pc + 32'd4;
  assign misaligned = |next_pc[1:0];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, fetches one instruction at a time and
// hands it to decode; every output comes straight from a flop.
module instruction_fetch import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic [1:0]  pc_source_i,
  input  logic [31:0] immediate_i,
  input  logic [31:0] alu_result_i,
  output logic        fault_o
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d, next_pc;
  logic req_q, req_d, valid_q, valid_d, fault_q, fault_d, misaligned;
  next_pc_unit u_next_pc (
    .pc(pc_q),
    .pc_source(pc_source_i),
    .immediate(immediate_i),
    .alu_result(alu_result_i),
    .next_pc(next_pc),
    .misaligned(misaligned)
  );
  // a grant only counts once the request is actually visible on the port
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      REQ: state_d = req_q && imem_gnt_i ? WAIT : REQ;
      WAIT: begin
        state_d = imem_rvalid_i ? VALID : WAIT;
        instr_d = imem_rvalid_i ? imem_rdata_i : instr_q;
      end
      VALID: if (instr_ready_i) begin
        state_d = misaligned ? HALT : REQ;
        fault_d = misaligned;
        pc_d = misaligned ? pc_q : next_pc;
      end
      default: ;
    endcase
    pc4_d = pc_d + 32'd4;
    req_d = state_d == REQ;
    valid_d = state_d == VALID;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      pc4_q <= RESET_PC + 32'd4;
      instr_q <= NOP_INSTR;
      req_q <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pc4_q <= pc4_d;
      instr_q <= instr_d;
      req_q <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end
  assign imem_req_o = req_q;
  assign imem_addr_o = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o = pc_q;
  assign pc_plus4_o = pc4_q;
  assign fault_o = fault_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench; fetched words are queued at grant
// and compared when the fetch stage presents them.
module tb_instruction_fetch;
  logic clk = 0, rst = 1;
  logic imem_req_o, imem_gnt_i = 0, imem_rvalid_i = 0;
  logic [31:0] imem_addr_o, imem_rdata_i = 0;
  logic instr_valid_o, instr_ready_i = 0, fault_o;
  logic [31:0] instr_o, pc_o, pc_plus4_o, immediate_i = 0, alu_result_i = 0;
  logic [1:0] pc_source_i = 0;
  int total = 0, passed = 0;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
  item_t sb[$];
  item_t cur;

  instruction_fetch #(.RESET_PC(32'h100)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .pc_source_i(pc_source_i), .immediate_i(immediate_i), .alu_result_i(alu_result_i),
    .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h100 ? 32'h0050_0093 : {a[15:0] ^ 16'h5a5a, 16'h0013};
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [31:0] imm, input logic [31:0] alu);
    return src == 2'b01 ? pc + imm : src == 2'b10 ? {alu[31:1], 1'b0} : pc + 32'd4;
  endfunction

  task automatic pop_check();
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    cur = sb.pop_front();
    chk("valid", instr_valid_o, 1);
    chk("instr", instr_o, cur.instr);
    chk("pc", pc_o, cur.pc);
    chk("pc_plus4", pc_plus4_o, cur.pc + 32'd4);
  endtask

  task automatic retire(input int rw, input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] alu);
    for (int i = 0; i < rw; i++) begin
      pc_source_i = 2'($urandom);
      immediate_i = $urandom;
      alu_result_i = $urandom;
      imem_gnt_i = 1;
      tick();
      chk("bp_valid", instr_valid_o, 1);
      chk("bp_instr", instr_o, cur.instr);
      chk("bp_pc", pc_o, cur.pc);
      chk("bp_req", imem_req_o, 0);
    end
    imem_gnt_i = 0;
    pc_source_i = src;
    immediate_i = imm;
    alu_result_i = alu;
    instr_ready_i = 1;
    tick();
    instr_ready_i = 0;
  endtask

  task automatic fetch(input logic [31:0] exp_addr, input int gw, input int rw,
                       input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    int n = 0;
    while (!imem_req_o && n < 10) begin tick(); n++; end
    chk("req_rise", imem_req_o, 1);
    chk("req_addr", imem_addr_o, exp_addr);
    chk("req_novalid", instr_valid_o, 0);
    for (int i = 0; i < gw; i++) begin
      instr_ready_i = 1;
      tick();
      chk("req_hold", imem_req_o, 1);
      chk("addr_hold", imem_addr_o, exp_addr);
    end
    instr_ready_i = 0;
    sb.push_back('{exp_addr, mem_word(exp_addr)});
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    chk("one_grant", imem_req_o, 0);
    chk("wait_novalid", instr_valid_o, 0);
    imem_rvalid_i = 1;
    imem_rdata_i = mem_word(exp_addr);
    tick();
    imem_rvalid_i = 0;
    imem_rdata_i = $urandom;
    pop_check();
    retire(rw, src, imm, alu);
  endtask

  initial begin
    logic [31:0] pc;
    imem_gnt_i = 1;
    tick(); tick();
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 32'h100);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 32'h13);
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_fault", fault_o, 0);
    rst = 0;
    tick();
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, 32'h100);
    sb.push_back('{32'h100, 32'h0050_0093});
    tick();
    chk("first_wait", imem_req_o, 0);
    imem_rvalid_i = 1;
    imem_rdata_i = 32'h0050_0093;
    tick();
    imem_rvalid_i = 0;
    imem_gnt_i = 0;
    pop_check();
    retire(5, 2'b01, 32'h100, 32'h0);
    pc = model_next(32'h100, 2'b01, 32'h100, 32'h0);
    fetch(pc, 4, 0, 2'b01, 32'hFFFF_FFF0, 32'h0);
    pc = model_next(pc, 2'b01, 32'hFFFF_FFF0, 32'h0);
    fetch(pc, 0, 2, 2'b10, 32'h0, 32'h0000_0305);
    pc = model_next(pc, 2'b10, 32'h0, 32'h0000_0305);
    chk("jalr_nofault", fault_o, 0);
    fetch(pc, 1, 0, 2'b10, 32'h0, 32'hFFFF_FFFD);
    pc = model_next(pc, 2'b10, 32'h0, 32'hFFFF_FFFD);
    fetch(pc, 0, 0, 2'b00, 32'h0, 32'h0);
    pc = model_next(pc, 2'b00, 32'h0, 32'h0);
    chk("wrap_nofault", fault_o, 0);
    fetch(pc, 0, 1, 2'b11, 32'h8, 32'h0);
    pc = model_next(pc, 2'b11, 32'h8, 32'h0);
    fetch(pc, 0, 0, 2'b10, 32'h0, 32'h0000_0011);
    pc = model_next(pc, 2'b10, 32'h0, 32'h0000_0011);
    fetch(pc, 0, 0, 2'b01, 32'h2, 32'h0);
    chk("fault_set", fault_o, 1);
    chk("fault_valid", instr_valid_o, 0);
    chk("fault_req", imem_req_o, 0);
    imem_gnt_i = 1;
    imem_rvalid_i = 1;
    instr_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req", imem_req_o, 0);
      chk("halt_fault", fault_o, 1);
      chk("halt_valid", instr_valid_o, 0);
    end
    imem_gnt_i = 0;
    imem_rvalid_i = 0;
    instr_ready_i = 0;
    rst = 1;
    #1;
    chk("clr_fault", fault_o, 0);
    chk("clr_addr", imem_addr_o, 32'h100);
    tick();
    rst = 0;
    fetch(32'h100, 0, 0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("w_req", imem_req_o, 1);
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    chk("w_wait", imem_req_o, 0);
    #2 rst = 1;
    #1;
    chk("wrst_req", imem_req_o, 0);
    chk("wrst_valid", instr_valid_o, 0);
    chk("wrst_addr", imem_addr_o, 32'h100);
    tick();
    rst = 0;
    tick();
    chk("restart_req", imem_req_o, 1);
    chk("restart_addr", imem_addr_o, 32'h100);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
